// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: FSM state encoding, 8N1 frame levels and default bit timing.
// Imported by both the transmit and receive paths.
package uart_tx_serializer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   localparam int   DATA_BITS          = 8;
   localparam logic START_LEVEL        = 1'b0;
   localparam logic STOP_LEVEL         = 1'b1;
   localparam logic IDLE_LEVEL         = 1'b1;
   localparam int   DEFAULT_BIT_CYCLES = 16;

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock byte FIFO; head byte readable combinationally, flags one cycle after push/pop.
// Writes while full are dropped; the full test uses pre-pop occupancy.
module uart_tx_sync_fifo #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk_tf,
   input  logic       rst,
   input  logic [7:0] wr_dat_i,
   input  logic       wr_vld_i,
   input  logic       rd_pop_i,
   output logic [7:0] rd_dat_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        push, pop;

   assign push     = wr_vld_i && !full_o;
   assign pop      = rd_pop_i && !empty_o;
   assign wr_ptr_d = wr_ptr_q + (AW+1)'(push);
   assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

   // Extra pointer MSB distinguishes a full ring from an empty one.
   assign empty_o  = (wr_ptr_q == rd_ptr_q);
   assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_tf) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_tf) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter fed by a small byte FIFO; line falls two cycles after a write into an idle block.
// Producer is throttled only through tf_full; back-to-back frames have no idle gap.
module uart_tx_serializer
   import uart_tx_serializer_pkg::*;
#(
   parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk_tf,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       wr_en,
   output logic       tf_full,
   output logic       tf_empty,
   output logic       tx_busy,
   output logic       transmitter_tx
);

   localparam int             CW       = $clog2(BIT_CYCLES);
   localparam logic [CW-1:0]  CYC_LAST = CW'(BIT_CYCLES - 1);
   localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

   uart_state_e   state_q;
   logic [CW-1:0] cyc_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          tx_q;
   logic          busy_q;
   logic [7:0]    fifo_dat;
   logic          bit_end;
   logic          pop;

   uart_tx_sync_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_tf   (clk_tf),
      .rst      (rst),
      .wr_dat_i (din),
      .wr_vld_i (wr_en),
      .rd_pop_i (pop),
      .rd_dat_o (fifo_dat),
      .full_o   (tf_full),
      .empty_o  (tf_empty)
   );

   assign bit_end = (cyc_q == CYC_LAST);
   assign pop     = !tf_empty &&
                    ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));

   // Line and busy are registered from the current state, so they trail the state by one cycle.
   always_ff @(posedge clk_tf) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cyc_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= IDLE_LEVEL;
         busy_q  <= 1'b0;
      end else begin
         busy_q <= (state_q != ST_IDLE);
         cyc_q  <= bit_end ? '0 : cyc_q + CW'(1);
         case (state_q)
            ST_IDLE: begin
               tx_q  <= IDLE_LEVEL;
               cyc_q <= '0;
               if (!tf_empty) begin
                  shift_q <= fifo_dat;
                  bit_q   <= '0;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               tx_q <= START_LEVEL;
               if (bit_end) begin
                  state_q <= ST_DATA;
               end
            end
            ST_DATA: begin
               tx_q <= shift_q[0];
               if (bit_end) begin
                  shift_q <= {1'b0, shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == BIT_LAST) begin
                     state_q <= ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               tx_q <= STOP_LEVEL;
               if (bit_end) begin
                  if (!tf_empty) begin
                     shift_q <= fifo_dat;
                     bit_q   <= '0;
                     state_q <= ST_START;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               tx_q    <= IDLE_LEVEL;
               cyc_q   <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign transmitter_tx = tx_q;
   assign tx_busy        = busy_q;

endmodule
